// File: rtl/uart_nic.sv
// uart_nic: byte-oriented network interface for the UART OS simulator.
//   The transmit path buffers bytes written by the OS in a TX FIFO and serialises
//   them 8N1 on uart_tx. The receive path synchronises uart_rx, deserialises 8N1
//   frames into an RX FIFO and returns one byte per read_nic.
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   write_nic           push send_data_to_nic[7:0] into the TX FIFO
//   read_nic            pop one byte from the RX FIFO into rec_data_from_nic[7:0]
//   send_data_i         RX FIFO non-empty
//   tx_full             TX FIFO full
//   tx_overflow         sticky: write while TX FIFO full
//   rx_overflow         sticky: received byte dropped because RX FIFO full
//   frame_err           sticky: stop bit sampled low
//   clr_err             synchronous clear of the sticky flags (a new error wins)
//   uart_rx / uart_tx   serial line in / out (idle high)
module uart_nic #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write_nic,
    input  logic [7:0] send_data_to_nic,
    input  logic       read_nic,
    output logic [7:0] rec_data_from_nic,
    output logic       send_data_i,
    output logic       tx_full,
    output logic       tx_overflow,
    output logic       rx_overflow,
    output logic       frame_err,
    input  logic       clr_err,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_REARM} rx_state_t;

    // Full when the wrap bits differ and the address bits match.
    function automatic logic ptr_full(input logic [FIFO_AW:0] wr, input logic [FIFO_AW:0] rd);
        return (wr[FIFO_AW] != rd[FIFO_AW]) && (wr[FIFO_AW-1:0] == rd[FIFO_AW-1:0]);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem_r [DEPTH];
    logic [FIFO_AW:0] tx_wr_r, tx_rd_r, tx_wr_n, tx_rd_n;
    logic             tx_full_r, tx_overflow_r, tx_empty_s, tx_push_s, tx_pop_s;
    logic [7:0]       tx_head_s;

    assign tx_empty_s = (tx_wr_r == tx_rd_r);
    assign tx_push_s  = write_nic & ~tx_full_r;
    assign tx_head_s  = tx_mem_r[tx_rd_r[FIFO_AW-1:0]];
    assign tx_wr_n    = tx_wr_r + {{FIFO_AW{1'b0}}, tx_push_s};
    assign tx_rd_n    = tx_rd_r + {{FIFO_AW{1'b0}}, tx_pop_s};

    // TX FIFO storage; contents are don't-care while pointers say empty.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wr_r[FIFO_AW-1:0]] <= send_data_to_nic;
    end

    // TX pointers, registered full flag and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_r       <= '0;
            tx_rd_r       <= '0;
            tx_full_r     <= 1'b0;
            tx_overflow_r <= 1'b0;
        end else begin
            tx_wr_r   <= tx_wr_n;
            tx_rd_r   <= tx_rd_n;
            tx_full_r <= ptr_full(tx_wr_n, tx_rd_n);
            if (write_nic && tx_full_r) tx_overflow_r <= 1'b1;
            else if (clr_err)           tx_overflow_r <= 1'b0;
            else                        tx_overflow_r <= tx_overflow_r;
        end
    end

    // ---------------- TX serialiser ----------------
    tx_state_t     tx_state_r, tx_state_n;
    logic [CW-1:0] tx_cnt_r, tx_cnt_n;
    logic [2:0]    tx_bit_r, tx_bit_n;
    logic [7:0]    tx_shift_r, tx_shift_n;
    logic          tx_line_r, tx_line_n;

    // TX state register; line resets high so reset mid-frame idles the wire at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shift_r <= tx_shift_n;
            tx_line_r  <= tx_line_n;
        end
    end

    // TX next-state: STOP hands straight to START when more data waits (no idle gap).
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bit_n   = tx_bit_r;
        tx_shift_n = tx_shift_r;
        tx_line_n  = tx_line_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_n = tx_head_s;
                    tx_cnt_n   = BIT_LAST;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end else begin
                    tx_line_n  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == '0) begin
                    tx_cnt_n   = BIT_LAST;
                    tx_bit_n   = 3'd0;
                    tx_line_n  = tx_shift_r[0];
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt_r - CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == '0) begin
                    tx_cnt_n = BIT_LAST;
                    if (tx_bit_r == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                        tx_line_n  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r - CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_r != '0) begin
                    tx_cnt_n = tx_cnt_r - CW'(1);
                end else if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_n = tx_head_s;
                    tx_cnt_n   = BIT_LAST;
                    tx_line_n  = 1'b0;
                    tx_state_n = TX_START;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    // ---------------- RX path ----------------
    logic             rx_meta_r, rx_sync_r;
    rx_state_t        rx_state_r, rx_state_n;
    logic [CW-1:0]    rx_cnt_r, rx_cnt_n;
    logic [2:0]       rx_bit_r, rx_bit_n;
    logic [7:0]       rx_shift_r, rx_shift_n;
    logic             rx_done_s, rx_ferr_s;
    logic [7:0]       rx_mem_r [DEPTH];
    logic [FIFO_AW:0] rx_wr_r, rx_rd_r, rx_wr_n, rx_rd_n;
    logic             rx_empty_s, rx_full_s, rx_push_s, rx_pop_s;
    logic [7:0]       rec_r;
    logic             send_data_r, rx_overflow_r, frame_err_r;

    assign rx_empty_s = (rx_wr_r == rx_rd_r);
    assign rx_full_s  = ptr_full(rx_wr_r, rx_rd_r);
    assign rx_pop_s   = read_nic & ~rx_empty_s;
    // A pop in the same cycle frees the slot the new byte lands in.
    assign rx_push_s  = rx_done_s & (~rx_full_s | rx_pop_s);
    assign rx_wr_n    = rx_wr_r + {{FIFO_AW{1'b0}}, rx_push_s};
    assign rx_rd_n    = rx_rd_r + {{FIFO_AW{1'b0}}, rx_pop_s};

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
        end
    end

    // RX next-state: mid-bit sampling, glitch rejection at mid start bit, re-arm on high line.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_cnt_n   = rx_cnt_r;
        rx_bit_n   = rx_bit_r;
        rx_shift_n = rx_shift_r;
        rx_done_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_cnt_n   = HALF_LAST;
                    rx_state_n = RX_START;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r != '0) begin
                    rx_cnt_n = rx_cnt_r - CW'(1);
                end else if (!rx_sync_r) begin
                    rx_cnt_n   = BIT_LAST;
                    rx_bit_n   = 3'd0;
                    rx_state_n = RX_DATA;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == '0) begin
                    rx_cnt_n   = BIT_LAST;
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == '0) begin
                    rx_done_s  = rx_sync_r;
                    rx_ferr_s  = ~rx_sync_r;
                    rx_state_n = RX_REARM;
                end else begin
                    rx_cnt_n = rx_cnt_r - CW'(1);
                end
            end
            RX_REARM: begin
                if (rx_sync_r) rx_state_n = RX_IDLE;
                else           rx_state_n = RX_REARM;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_push_s) rx_mem_r[rx_wr_r[FIFO_AW-1:0]] <= rx_shift_r;
    end

    // RX pointers, read data register, availability and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_r       <= '0;
            rx_rd_r       <= '0;
            rec_r         <= 8'h00;
            send_data_r   <= 1'b0;
            rx_overflow_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            rx_wr_r     <= rx_wr_n;
            rx_rd_r     <= rx_rd_n;
            send_data_r <= (rx_wr_n != rx_rd_n);
            if (rx_pop_s) rec_r <= rx_mem_r[rx_rd_r[FIFO_AW-1:0]];
            else          rec_r <= rec_r;
            if (rx_done_s && !rx_push_s) rx_overflow_r <= 1'b1;
            else if (clr_err)            rx_overflow_r <= 1'b0;
            else                         rx_overflow_r <= rx_overflow_r;
            if (rx_ferr_s)    frame_err_r <= 1'b1;
            else if (clr_err) frame_err_r <= 1'b0;
            else              frame_err_r <= frame_err_r;
        end
    end

    assign uart_tx           = tx_line_r;
    assign tx_full           = tx_full_r;
    assign tx_overflow       = tx_overflow_r;
    assign rec_data_from_nic = rec_r;
    assign send_data_i       = send_data_r;
    assign rx_overflow       = rx_overflow_r;
    assign frame_err         = frame_err_r;

endmodule

// File: tb/tb_uart_nic.sv
// tb_uart_nic: directed self-checking bench for uart_nic with CLKS_PER_BIT=4, FIFO_AW=2.
//   A table of {byte, expected 10-bit line frame} drives TX and RX checks in a loop;
//   hand-written sequences cover overflow, framing error, glitch and mid-frame reset.
module tb_uart_nic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_nic;
    logic [7:0] send_data_to_nic;
    logic       read_nic;
    logic [7:0] rec_data_from_nic;
    logic       send_data_i;
    logic       tx_full;
    logic       tx_overflow;
    logic       rx_overflow;
    logic       frame_err;
    logic       clr_err;
    logic       uart_rx;
    logic       uart_tx;

    int n_cmp = 0;
    int n_err = 0;

    uart_nic #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .write_nic         (write_nic),
        .send_data_to_nic  (send_data_to_nic),
        .read_nic          (read_nic),
        .rec_data_from_nic (rec_data_from_nic),
        .send_data_i       (send_data_i),
        .tx_full           (tx_full),
        .tx_overflow       (tx_overflow),
        .rx_overflow       (rx_overflow),
        .frame_err         (frame_err),
        .clr_err           (clr_err),
        .uart_rx           (uart_rx),
        .uart_tx           (uart_tx)
    );

    always #5 clk = ~clk;

    // frame[0] = start bit, frame[8:1] = data LSB first, frame[9] = stop bit
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one 8N1 frame on uart_rx, 4 clocks per bit, line left high.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = bits[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic read_pulse();
        @(negedge clk);
        read_nic = 1'b1;
        @(negedge clk);
        read_nic = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Per-byte TX check: each bit sampled on its first and last clock.
    task automatic tx_vector(input vec_t v, input int idx);
        @(negedge clk);
        write_nic        = 1'b1;
        send_data_to_nic = v.data;
        @(posedge clk);
        @(negedge clk);
        write_nic = 1'b0;
        check($sformatf("tx_prestart v%0d", idx), {31'd0, uart_tx}, 32'd1);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("tx_first v%0d b%0d", idx, k), {31'd0, uart_tx}, {31'd0, v.frame[k]});
            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("tx_last v%0d b%0d", idx, k), {31'd0, uart_tx}, {31'd0, v.frame[k]});
            @(posedge clk);
        end
        repeat (3) @(negedge clk);
        check($sformatf("tx_idle v%0d", idx), {31'd0, uart_tx}, 32'd1);
    endtask

    // Per-byte RX check including the OS's trailing read on an empty FIFO.
    task automatic rx_vector(input vec_t v, input int idx);
        rx_frame(v.data, 1'b1);
        repeat (2) @(negedge clk);
        check($sformatf("rx_avail v%0d", idx), {31'd0, send_data_i}, 32'd1);
        read_nic = 1'b1;
        @(negedge clk);
        check($sformatf("rx_rec v%0d", idx), {24'd0, rec_data_from_nic}, {24'd0, v.data});
        check($sformatf("rx_empty v%0d", idx), {31'd0, send_data_i}, 32'd0);
        @(negedge clk);
        read_nic = 1'b0;
        check($sformatf("rx_rec_hold v%0d", idx), {24'd0, rec_data_from_nic}, {24'd0, v.data});
    endtask

    logic [7:0] burst [6];
    logic       saw_low;

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{data: 8'h3C, frame: 10'h278};
        vecs[2] = '{data: 8'h00, frame: 10'h200};
        vecs[3] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[4] = '{data: 8'h81, frame: 10'h302};
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        rst_n            = 1'b0;
        write_nic        = 1'b0;
        send_data_to_nic = 8'h00;
        read_nic         = 1'b0;
        clr_err          = 1'b0;
        uart_rx          = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_rec", {24'd0, rec_data_from_nic}, 32'd0);
        check("rst_send_data_i", {31'd0, send_data_i}, 32'd0);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_tx_overflow", {31'd0, tx_overflow}, 32'd0);
        check("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            tx_vector(vecs[i], i);
            rx_vector(vecs[i], i);
        end

        // TX burst: one byte moves to the shifter, then 4 fill the FIFO, the 6th is dropped.
        fork
            begin
                @(negedge clk);
                write_nic        = 1'b1;
                send_data_to_nic = burst[0];
                @(posedge clk);
                @(negedge clk);
                write_nic = 1'b0;
                @(posedge clk);
                for (int i = 1; i < 6; i++) begin
                    @(negedge clk);
                    if (i == 5) begin
                        check("burst_full", {31'd0, tx_full}, 32'd1);
                        check("burst_no_ovf_yet", {31'd0, tx_overflow}, 32'd0);
                    end
                    write_nic        = 1'b1;
                    send_data_to_nic = burst[i];
                    @(posedge clk);
                end
                @(negedge clk);
                write_nic = 1'b0;
                check("burst_ovf", {31'd0, tx_overflow}, 32'd1);
            end
            begin
                logic exp_bit;
                @(negedge clk);
                @(posedge clk);
                @(posedge clk);
                for (int j = 0; j < 50; j++) begin
                    if (j % 10 == 0)      exp_bit = 1'b0;
                    else if (j % 10 == 9) exp_bit = 1'b1;
                    else                  exp_bit = burst[j / 10][(j % 10) - 1];
                    @(negedge clk);
                    check($sformatf("burst_line bit%0d", j), {31'd0, uart_tx}, {31'd0, exp_bit});
                    repeat (4) @(posedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);
        check("burst_idle", {31'd0, uart_tx}, 32'd1);
        check("burst_drained", {31'd0, tx_full}, 32'd0);
        check("burst_ovf_sticky", {31'd0, tx_overflow}, 32'd1);
        clear_errors();
        check("burst_ovf_clr", {31'd0, tx_overflow}, 32'd0);

        // RX overflow: 4 frames fill the FIFO, the 5th is dropped.
        for (int i = 0; i < 4; i++) rx_frame(8'(i + 1), 1'b1);
        repeat (2) @(negedge clk);
        check("rxovf_not_yet", {31'd0, rx_overflow}, 32'd0);
        rx_frame(8'h05, 1'b1);
        repeat (2) @(negedge clk);
        check("rxovf_set", {31'd0, rx_overflow}, 32'd1);
        check("rxovf_avail", {31'd0, send_data_i}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            read_pulse();
            check($sformatf("rxovf_pop%0d", i), {24'd0, rec_data_from_nic}, i + 1);
        end
        check("rxovf_empty", {31'd0, send_data_i}, 32'd0);
        clear_errors();
        check("rxovf_clr", {31'd0, rx_overflow}, 32'd0);

        // Stop bit low: framing error, nothing stored.
        rx_frame(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("ferr_nothing_pushed", {31'd0, send_data_i}, 32'd0);
        clear_errors();
        check("ferr_clr", {31'd0, frame_err}, 32'd0);

        // One-clock low glitch is rejected; a real frame afterwards still arrives.
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_no_data", {31'd0, send_data_i}, 32'd0);
        check("glitch_no_ferr", {31'd0, frame_err}, 32'd0);
        rx_frame(8'h96, 1'b1);
        repeat (2) @(negedge clk);
        read_pulse();
        check("glitch_then_frame", {24'd0, rec_data_from_nic}, 32'h96);

        // Reset in the middle of a TX data bit with more data queued.
        @(negedge clk);
        write_nic        = 1'b1;
        send_data_to_nic = 8'h00;
        repeat (2) @(negedge clk);
        write_nic = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_pre_low", {31'd0, uart_tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_high", {31'd0, uart_tx}, 32'd1);
        check("rst_mid_rec", {24'd0, rec_data_from_nic}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        check("rst_mid_no_frame", {31'd0, saw_low}, 32'd0);
        check("rst_mid_tx_full", {31'd0, tx_full}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
